// File: rtl/cpu_step_ctrl.sv
// Clock-enable execution controller for the KLP32 core: run at a programmable
// rate, debounced single-step, halt, and a PC breakpoint.
module cpu_step_ctrl #(
  parameter int DIV_W           = 24,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PC_W            = 32,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [1:0]       i_mode,
  input  logic             i_step_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_cpu_en,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_en_count
);

  // state | meaning
  // HALT  | core frozen, waiting for a run or step mode
  // RUN   | divider-paced enable pulses
  // STEP  | one enable pulse per debounced button press
  // BRK   | breakpoint hit; only a button press releases one pulse
  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BRK  = 2'b11
  } stateT;

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam int         DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       rstSync;
  logic             rstN;
  logic [1:0]       modeMeta, modeSync;
  logic             stepMeta, stepSync;
  logic             bpMeta, bpSync;
  logic             debLevel;
  logic [DB_W-1:0]  debCnt;
  logic             pressEvt;
  stateT            state;
  logic             cpuEn;
  logic [DIV_W-1:0] divCnt;
  logic             armed;
  logic [CNT_W-1:0] enCount;
  logic             haltReq;
  logic             bpHit;

  // Reset asserts immediately, releases two clocks later.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) rstSync <= 2'b00;
    else           rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  // Synchronizers run off the raw reset so they are already filling while
  // the reset synchronizer releases.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      modeMeta <= 2'b00;
      modeSync <= 2'b00;
      stepMeta <= 1'b1;
      stepSync <= 1'b1;
      bpMeta   <= 1'b0;
      bpSync   <= 1'b0;
    end else begin
      modeMeta <= i_mode;
      modeSync <= modeMeta;
      stepMeta <= i_step_n;
      stepSync <= stepMeta;
      bpMeta   <= i_bp_en;
      bpSync   <= bpMeta;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      debLevel <= 1'b1;
      debCnt   <= '0;
      pressEvt <= 1'b0;
    end else begin
      pressEvt <= 1'b0;
      if (stepSync == debLevel) begin
        debCnt <= '0;
      end else if (debCnt == DB_LAST) begin
        debLevel <= stepSync;
        debCnt   <= '0;
        pressEvt <= ~stepSync;
      end else begin
        debCnt <= debCnt + DB_W'(1);
      end
    end
  end

  assign haltReq = (modeSync == 2'b00) || (modeSync == 2'b11);
  assign bpHit   = bpSync && armed && (i_pc == i_bp_addr);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= HALT;
      cpuEn   <= 1'b0;
      divCnt  <= '0;
      armed   <= 1'b1;
      enCount <= '0;
    end else begin
      cpuEn <= 1'b0;
      if (cpuEn) enCount <= enCount + CNT_W'(1);
      if (i_pc != i_bp_addr) armed <= 1'b1;
      case (state)
        HALT: begin
          if (modeSync == MODE_RUN) begin
            state  <= RUN;
            divCnt <= i_div;
          end else if (modeSync == MODE_STEP) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (haltReq) begin
            state <= HALT;
          end else if (bpHit) begin
            state <= BRK;
            armed <= 1'b0;
          end else if (modeSync == MODE_STEP) begin
            state <= STEP;
          end else if (divCnt == '0) begin
            cpuEn  <= 1'b1;
            divCnt <= i_div;
          end else begin
            divCnt <= divCnt - DIV_W'(1);
          end
        end
        STEP: begin
          if (haltReq) begin
            state <= HALT;
          end else if (bpHit) begin
            state <= BRK;
            armed <= 1'b0;
          end else if (modeSync == MODE_RUN) begin
            state  <= RUN;
            divCnt <= i_div;
          end else begin
            cpuEn <= pressEvt;
          end
        end
        BRK: begin
          // A press releases exactly one instruction, then the mode decides.
          if (haltReq) begin
            state <= HALT;
          end else if (pressEvt) begin
            cpuEn <= 1'b1;
            if (modeSync == MODE_RUN) begin
              state  <= RUN;
              divCnt <= i_div;
            end else begin
              state <= STEP;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign o_cpu_en   = cpuEn;
  assign o_state    = state;
  assign o_halted   = (state == HALT) || (state == BRK);
  assign o_en_count = enCount;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: reset, run rate, debounce, breakpoint,
// mode override and asynchronous reset.
module tb_cpu_step_ctrl;

  localparam int DIV_W = 24;
  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             resetIn;
  logic [1:0]       mode;
  logic             stepN;
  logic [DIV_W-1:0] div;
  logic             bpEn;
  logic [PC_W-1:0]  bpAddr;
  logic [PC_W-1:0]  pc;
  logic             cpuEn;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] enCount;
  logic [PC_W-1:0]  pcReg;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DIV_W(DIV_W), .DEBOUNCE_CYCLES(4), .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_in(resetIn), .i_mode(mode), .i_step_n(stepN),
    .i_div(div), .i_bp_en(bpEn), .i_bp_addr(bpAddr), .i_pc(pc),
    .o_cpu_en(cpuEn), .o_state(state), .o_halted(halted),
    .o_en_count(enCount)
  );

  // Core model: pcReg is the instruction executing while enable is high;
  // i_pc shows the PC the next enable pulse would execute.
  always @(posedge clk or negedge resetIn) begin
    if (!resetIn)   pcReg <= '0;
    else if (cpuEn) pcReg <= pcReg + 32'd4;
  end
  assign pc = pcReg + (cpuEn ? 32'd4 : 32'd0);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic countPulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      if (cpuEn) pulses++;
    end
  endtask

  task automatic waitState(input logic [1:0] s, input int budget, input string tag);
    int k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    chk(tag, state, s);
  endtask

  task automatic waitPulse(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpuEn && n < budget);
  endtask

  initial begin
    int n;
    int p;
    int brkCycles;
    logic [PC_W-1:0] pulsePc;

    resetIn = 1'b0;
    mode    = 2'b01;
    stepN   = 1'b1;
    div     = 24'd3;
    bpEn    = 1'b0;
    bpAddr  = 32'h10;

    repeat (3) tick();
    chk("reset en", cpuEn, 1'b0);
    chk("reset state", state, 2'b00);
    chk("reset halted", halted, 1'b1);
    chk("reset count", enCount, 0);

    resetIn = 1'b1;
    tick();
    tick();
    chk("still halt 2 after release", state, 2'b00);
    tick();
    chk("run 3 after release", state, 2'b01);
    chk("run halted", halted, 1'b0);
    waitPulse(20, n);
    chk("first pulse latency div3", n, 4);
    chk("count at first pulse", enCount, 0);

    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("div3 cycle %0d", i), cpuEn, (i % 4) == 0);
    end
    chk("count after 40 cycles", enCount, 10);

    div = 24'd0;
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("div0 cycle %0d", i), cpuEn, 1'b1);
    end

    // Mode override mid-count
    div = 24'd100;
    repeat (10) tick();
    mode = 2'b00;
    p = 0;
    repeat (3) begin
      tick();
      if (cpuEn) p++;
    end
    chk("halt within 3", state, 2'b00);
    chk("halt halted", halted, 1'b1);
    countPulses(5, n);
    chk("override pulses", p + n, 0);
    mode = 2'b01;
    waitState(2'b01, 10, "rerun state");
    waitPulse(200, n);
    chk("rerun latency div100", n, 101);

    // Debounced single step
    mode = 2'b10;
    waitState(2'b10, 10, "step state");
    p = 0;
    for (int i = 0; i < 20; i++) begin
      stepN = ((i >> 1) & 1) != 0;
      tick();
      if (cpuEn) p++;
    end
    chk("bounce pulses", p, 0);
    stepN = 1'b0;
    countPulses(20, n);
    chk("press pulse cycles", n, 1);
    countPulses(30, n);
    chk("held low pulses", n, 0);
    stepN = 1'b1;
    countPulses(20, n);
    chk("release pulses", n, 0);
    stepN = 1'b0;
    countPulses(20, n);
    chk("second press pulse cycles", n, 1);
    stepN = 1'b1;

    // Breakpoint from a fresh reset, pc starting at 0
    resetIn = 1'b0;
    mode    = 2'b01;
    div     = 24'd0;
    bpEn    = 1'b1;
    bpAddr  = 32'h10;
    repeat (2) tick();
    resetIn = 1'b1;
    p = 0;
    n = 0;
    while (state !== 2'b11 && n < 30) begin
      tick();
      n++;
      if (cpuEn) begin
        chk($sformatf("bp pulse %0d pc", p), pcReg, p * 4);
        p++;
      end
    end
    chk("bp pulses before hit", p, 4);
    chk("bp state", state, 2'b11);
    chk("bp halted", halted, 1'b1);
    chk("bp en", cpuEn, 1'b0);
    chk("bp pc held", pcReg, 32'h10);

    div = 24'd20;
    countPulses(5, n);
    chk("brk idle pulses", n, 0);
    chk("brk holds with run mode", state, 2'b11);
    stepN = 1'b0;
    p = 0;
    pulsePc = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cpuEn) begin
        p++;
        pulsePc = pcReg;
      end
    end
    chk("brk press pulses", p, 1);
    chk("brk pulse pc", pulsePc, 32'h10);
    chk("pc after brk pulse", pcReg, 32'h14);
    chk("state after brk pulse", state, 2'b01);
    stepN = 1'b1;
    brkCycles = 0;
    repeat (40) begin
      tick();
      if (state === 2'b11) brkCycles++;
    end
    chk("no retrigger", brkCycles, 0);

    // Asynchronous reset between edges while enable is high
    bpEn = 1'b0;
    div  = 24'd0;
    waitPulse(50, n);
    chk("pulse before async reset", cpuEn, 1'b1);
    chk("count nonzero before reset", enCount != 0, 1'b1);
    #2;
    resetIn = 1'b0;
    #1;
    chk("async reset en", cpuEn, 1'b0);
    chk("async reset count", enCount, 0);
    chk("async reset state", state, 2'b00);
    chk("async reset halted", halted, 1'b1);
    tick();
    resetIn = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
